// File: rtl/hazard_pkg.sv
// Shared types and helpers for the RV32 pipeline hazard controller.
// Forward-select encoding is fixed because the E-stage operand muxes decode it directly.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   localparam int REG_AW_DEF = 5;

   // Compare width for src_match; register indices up to 8 bits are supported.
   localparam int IDX_W_MAX = 8;

   // True when a names a real register (not x0) and equals b.
   function automatic logic src_match(input logic [IDX_W_MAX-1:0] a,
                                      input logic [IDX_W_MAX-1:0] b);
      return (a != '0) && (a == b);
   endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Long-latency (MUL/DIV) writeback scoreboard: pending vector, in-flight count,
// sticky protocol-error flag and the RAW/WAW/capacity busy terms for the D stage.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_AW  = REG_AW_DEF,
   parameter int NUM_SRC = 2,
   parameter int LO_MAX  = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_SRC-1:0][REG_AW-1:0] rs_D,
   input  logic [REG_AW-1:0]              rd_D,
   input  logic                           lo_D,
   input  logic [REG_AW-1:0]              rd_E,
   input  logic                           lo_start_E,
   input  logic                           lo_done,
   input  logic [REG_AW-1:0]              lo_rd,
   output logic [NUM_SRC-1:0]             src_busy,
   output logic                           rd_busy,
   output logic                           cap_full,
   output logic                           sb_err
);

   localparam int NREG  = 2 ** REG_AW;
   localparam int CNT_W = $clog2(LO_MAX + 1);

   logic [NREG-1:0]  pending;
   logic [CNT_W-1:0] count;

   // A register completing this cycle is readable (write-first regfile), so it is not busy.
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src_busy
      assign src_busy[i] = (rs_D[i] != '0) && pending[rs_D[i]] &&
                           !(lo_done && (lo_rd == rs_D[i]));
   end

   assign rd_busy  = (rd_D != '0) && pending[rd_D] && !(lo_done && (lo_rd == rd_D));

   // Conservative: a same-cycle completion does not free a slot.
   assign cap_full = lo_D &&
                     (({1'b0, count} + (CNT_W + 1)'(lo_start_E)) >= (CNT_W + 1)'(LO_MAX));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
         count   <= '0;
         sb_err  <= 1'b0;
      end else begin
         // NOTE: non-blocking updates to the same bit resolve to the last one written,
         // so placing the set after the clear makes a same-index set win.
         if (lo_done)
            pending[lo_rd] <= 1'b0;
         if (lo_start_E && (rd_E != '0))
            pending[rd_E] <= 1'b1;

         case ({lo_start_E, lo_done})
            2'b10: begin
               if (count == CNT_W'(LO_MAX)) sb_err <= 1'b1;
               else                         count  <= count + CNT_W'(1);
            end
            2'b01: begin
               if (count == '0) sb_err <= 1'b1;
               else             count  <= count - CNT_W'(1);
            end
            default: ;
         endcase

         if (lo_done && (lo_rd != '0) && !pending[lo_rd])
            sb_err <= 1'b1;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32 core: E-stage forwarding selects,
// load-use detection and scoreboard-driven stalls combined into stall/flush controls.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_AW  = REG_AW_DEF,
   parameter int NUM_SRC = 2,
   parameter int LO_MAX  = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_SRC-1:0][REG_AW-1:0] rs_D,
   input  logic [REG_AW-1:0]              rd_D,
   input  logic                           lo_D,
   input  logic [NUM_SRC-1:0][REG_AW-1:0] rs_E,
   input  logic [REG_AW-1:0]              rd_E,
   input  logic                           load_E,
   input  logic                           lo_start_E,
   input  logic                           pc_src_E,
   input  logic [REG_AW-1:0]              rd_M,
   input  logic [REG_AW-1:0]              rd_W,
   input  logic                           reg_wr_M,
   input  logic                           reg_wr_W,
   input  logic                           lo_done,
   input  logic [REG_AW-1:0]              lo_rd,
   output logic [NUM_SRC-1:0][1:0]        fwd_sel_E,
   output logic                           stall_F,
   output logic                           stall_D,
   output logic                           flush_D,
   output logic                           flush_E,
   output logic                           sb_err
);

   logic [NUM_SRC-1:0] src_busy;
   logic               rd_busy;
   logic               cap_full;
   logic               load_use;
   logic               stall;

   hazard_scoreboard #(
      .REG_AW  (REG_AW),
      .NUM_SRC (NUM_SRC),
      .LO_MAX  (LO_MAX)
   ) u_sb (
      .clk        (clk),
      .rst        (rst),
      .rs_D       (rs_D),
      .rd_D       (rd_D),
      .lo_D       (lo_D),
      .rd_E       (rd_E),
      .lo_start_E (lo_start_E),
      .lo_done    (lo_done),
      .lo_rd      (lo_rd),
      .src_busy   (src_busy),
      .rd_busy    (rd_busy),
      .cap_full   (cap_full),
      .sb_err     (sb_err)
   );

   // M holds the younger result, so it takes priority over W.
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
      assign fwd_sel_E[i] =
         rst                                                        ? FWD_RF :
         (reg_wr_M && src_match(IDX_W_MAX'(rs_E[i]), IDX_W_MAX'(rd_M))) ? FWD_M  :
         (reg_wr_W && src_match(IDX_W_MAX'(rs_E[i]), IDX_W_MAX'(rd_W))) ? FWD_W  :
                                                                      FWD_RF;
   end

   always_comb begin
      // NOTE: default assignment first so no path leaves load_use unassigned (no latch).
      load_use = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (load_E && src_match(IDX_W_MAX'(rd_E), IDX_W_MAX'(rs_D[i])))
            load_use = 1'b1;
      end
   end

   assign stall = load_use || (|src_busy) || rd_busy || cap_full;

   // A taken branch bubbles D even while stalled; F stays held that cycle.
   assign stall_F = !rst && stall;
   assign stall_D = !rst && stall;
   assign flush_D = !rst && pc_src_E;
   assign flush_E = !rst && (stall || pc_src_E);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of forwarding, hazards and the long-op scoreboard.
module tb_hazard_ctrl;

   localparam int REG_AW  = 5;
   localparam int NUM_SRC = 2;
   localparam int LO_MAX  = 2;

   localparam logic [1:0] E_RF = 2'b00;
   localparam logic [1:0] E_W  = 2'b01;
   localparam logic [1:0] E_M  = 2'b10;

   logic clk = 1'b0;
   logic rst;
   logic [NUM_SRC-1:0][REG_AW-1:0] rs_D, rs_E;
   logic [REG_AW-1:0] rd_D, rd_E, rd_M, rd_W, lo_rd;
   logic lo_D, load_E, lo_start_E, pc_src_E, reg_wr_M, reg_wr_W, lo_done;
   logic [NUM_SRC-1:0][1:0] fwd_sel_E;
   logic stall_F, stall_D, flush_D, flush_E, sb_err;

   int errors = 0;
   int checks = 0;

   hazard_ctrl #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .LO_MAX(LO_MAX)) dut (
      .clk(clk), .rst(rst), .rs_D(rs_D), .rd_D(rd_D), .lo_D(lo_D),
      .rs_E(rs_E), .rd_E(rd_E), .load_E(load_E), .lo_start_E(lo_start_E),
      .pc_src_E(pc_src_E), .rd_M(rd_M), .rd_W(rd_W), .reg_wr_M(reg_wr_M),
      .reg_wr_W(reg_wr_W), .lo_done(lo_done), .lo_rd(lo_rd),
      .fwd_sel_E(fwd_sel_E), .stall_F(stall_F), .stall_D(stall_D),
      .flush_D(flush_D), .flush_E(flush_E), .sb_err(sb_err)
   );

   always #5 clk = ~clk;

   // {fwd[1], fwd[0], stall_F, stall_D, flush_D, flush_E, sb_err}
   logic [8:0] obs;
   assign obs = {fwd_sel_E, stall_F, stall_D, flush_D, flush_E, sb_err};

   // Behavioural model: set of outstanding long-op destinations, in-flight count, error flag.
   bit [31:0] m_pend;
   int        m_cnt;
   bit        m_err;

   always @(posedge clk or posedge rst) begin
      int nc;
      if (rst) begin
         m_pend <= '0;
         m_cnt  <= 0;
         m_err  <= 1'b0;
      end else begin
         nc = m_cnt + int'(lo_start_E) - int'(lo_done);
         if (lo_done && lo_rd != 0 && !m_pend[lo_rd]) m_err <= 1'b1;
         if (nc < 0 || nc > LO_MAX) m_err <= 1'b1;
         else                       m_cnt <= nc;
         if (lo_done) m_pend[lo_rd] <= 1'b0;
         if (lo_start_E && rd_E != 0) m_pend[rd_E] <= 1'b1;
      end
   end

   function automatic bit ready(input logic [REG_AW-1:0] r);
      return (r == 0) || !m_pend[r] || (lo_done && lo_rd == r);
   endfunction

   function automatic logic [8:0] exp_out();
      logic [1:0] f [NUM_SRC];
      bit st;
      if (rst) return '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (rs_E[i] == 0)                          f[i] = E_RF;
         else if (reg_wr_M && rd_M == rs_E[i])      f[i] = E_M;
         else if (reg_wr_W && rd_W == rs_E[i])      f[i] = E_W;
         else                                       f[i] = E_RF;
      end
      st = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (load_E && rd_E != 0 && rs_D[i] == rd_E) st = 1'b1;
         if (!ready(rs_D[i])) st = 1'b1;
      end
      if (!ready(rd_D)) st = 1'b1;
      if (lo_D && (m_cnt + int'(lo_start_E)) >= LO_MAX) st = 1'b1;
      return {f[1], f[0], st, st, pc_src_E, st | pc_src_E, m_err};
   endfunction

   task automatic idle();
      rs_D = '0; rd_D = '0; lo_D = 1'b0; rs_E = '0; rd_E = '0; load_E = 1'b0;
      lo_start_E = 1'b0; pc_src_E = 1'b0; rd_M = '0; rd_W = '0;
      reg_wr_M = 1'b0; reg_wr_W = 1'b0; lo_done = 1'b0; lo_rd = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      load_E = 1'b1; rd_E = 5'd7; rs_D = {5'd7, 5'd7}; pc_src_E = 1'b1;
      rd_M = 5'd5; reg_wr_M = 1'b1; rs_E = {5'd5, 5'd5}; lo_D = 1'b1;
      #1;
      if (obs !== 9'd0) begin errors++; $display("FAIL reset_outputs got=%b exp=%b", obs, 9'd0); end
      checks++;
      tick();
      if (obs !== 9'd0) begin errors++; $display("FAIL reset_held got=%b exp=%b", obs, 9'd0); end
      checks++;
      rst = 1'b0;
      idle();
      #1;
      if (obs !== 9'd0) begin errors++; $display("FAIL reset_release_idle got=%b exp=%b", obs, 9'd0); end
      checks++;
      tick();
   endtask

   task automatic test_forwarding();
      idle();
      rd_M = 5'd5; reg_wr_M = 1'b1; rs_E = {5'd5, 5'd5};
      #1;
      if (fwd_sel_E !== {E_M, E_M}) begin errors++; $display("FAIL fwd_m got=%b exp=%b", fwd_sel_E, {E_M, E_M}); end
      checks++;
      rd_W = 5'd5; reg_wr_W = 1'b1;
      #1;
      if (fwd_sel_E !== {E_M, E_M}) begin errors++; $display("FAIL fwd_m_over_w got=%b exp=%b", fwd_sel_E, {E_M, E_M}); end
      checks++;
      reg_wr_M = 1'b0; rs_E = {5'd6, 5'd5};
      #1;
      if (fwd_sel_E !== {E_RF, E_W}) begin errors++; $display("FAIL fwd_w got=%b exp=%b", fwd_sel_E, {E_RF, E_W}); end
      checks++;
      tick();
   endtask

   task automatic test_x0();
      idle();
      rd_M = 5'd0; reg_wr_M = 1'b1; rs_E = {5'd3, 5'd0};
      #1;
      if (fwd_sel_E !== {E_RF, E_RF}) begin errors++; $display("FAIL x0_fwd got=%b exp=%b", fwd_sel_E, {E_RF, E_RF}); end
      checks++;
      idle();
      load_E = 1'b1; rd_E = 5'd0; rs_D = '0;
      #1;
      if ({stall_F, stall_D, flush_E} !== 3'b000) begin
         errors++; $display("FAIL x0_load_use got=%b exp=%b", {stall_F, stall_D, flush_E}, 3'b000);
      end
      checks++;
      tick();
   endtask

   task automatic test_load_use();
      idle();
      load_E = 1'b1; rd_E = 5'd7; rs_D = {5'd7, 5'd2};
      #1;
      if ({stall_F, stall_D, flush_E, flush_D} !== 4'b1110) begin
         errors++; $display("FAIL load_use_stall got=%b exp=%b", {stall_F, stall_D, flush_E, flush_D}, 4'b1110);
      end
      checks++;
      tick();
      idle();
      rs_D = {5'd7, 5'd2}; rd_M = 5'd7; reg_wr_M = 1'b1;
      #1;
      if ({stall_F, stall_D, flush_E} !== 3'b000) begin
         errors++; $display("FAIL load_use_release got=%b exp=%b", {stall_F, stall_D, flush_E}, 3'b000);
      end
      checks++;
      tick();
      idle();
      rs_E = {5'd7, 5'd2}; rd_W = 5'd7; reg_wr_W = 1'b1;
      #1;
      if (fwd_sel_E !== {E_W, E_RF}) begin errors++; $display("FAIL load_use_fwd_w got=%b exp=%b", fwd_sel_E, {E_W, E_RF}); end
      checks++;
      tick();
   endtask

   task automatic test_div();
      do_reset();
      idle();
      lo_start_E = 1'b1; rd_E = 5'd9;
      #1;
      if (stall_D !== 1'b0) begin errors++; $display("FAIL div_issue got=%b exp=0", stall_D); end
      checks++;
      tick();
      idle();
      rs_D = {5'd0, 5'd9};
      for (int c = 0; c < 3; c++) begin
         #1;
         if (stall_D !== 1'b1) begin errors++; $display("FAIL div_raw_stall cyc=%0d got=%b exp=1", c, stall_D); end
         checks++;
         tick();
      end
      rs_D = '0; rd_D = 5'd9;
      #1;
      if (stall_D !== 1'b1) begin errors++; $display("FAIL div_waw_stall got=%b exp=1", stall_D); end
      checks++;
      rd_D = '0; rs_D = {5'd0, 5'd9}; lo_done = 1'b1; lo_rd = 5'd9;
      #1;
      if (stall_D !== 1'b0) begin errors++; $display("FAIL div_done_release got=%b exp=0", stall_D); end
      checks++;
      tick();
      lo_done = 1'b0; lo_rd = '0;
      #1;
      if ({stall_D, sb_err} !== 2'b00) begin errors++; $display("FAIL div_cleared got=%b exp=00", {stall_D, sb_err}); end
      checks++;
      tick();
   endtask

   task automatic test_capacity();
      do_reset();
      idle();
      lo_start_E = 1'b1; rd_E = 5'd10;
      tick();
      rd_E = 5'd11; lo_D = 1'b1;
      #1;
      if (stall_D !== 1'b1) begin errors++; $display("FAIL cap_start_plus_one got=%b exp=1", stall_D); end
      checks++;
      tick();
      idle();
      lo_D = 1'b1;
      #1;
      if (stall_D !== 1'b1) begin errors++; $display("FAIL cap_full got=%b exp=1", stall_D); end
      checks++;
      tick();
      idle();
      lo_start_E = 1'b1; rd_E = 5'd12; lo_done = 1'b1; lo_rd = 5'd10;
      tick();
      idle();
      lo_D = 1'b1;
      #1;
      if (stall_D !== 1'b1) begin errors++; $display("FAIL cap_swap_keeps_two got=%b exp=1", stall_D); end
      checks++;
      idle();
      lo_done = 1'b1; lo_rd = 5'd3;
      #1;
      if (sb_err !== 1'b0) begin errors++; $display("FAIL sb_err_early got=%b exp=0", sb_err); end
      checks++;
      tick();
      idle();
      lo_D = 1'b1;
      #1;
      if ({sb_err, stall_D} !== 2'b10) begin errors++; $display("FAIL sb_err_set got=%b exp=10", {sb_err, stall_D}); end
      checks++;
      tick();
   endtask

   task automatic test_branch_during_stall();
      do_reset();
      idle();
      load_E = 1'b1; rd_E = 5'd7; rs_D = {5'd0, 5'd7}; pc_src_E = 1'b1;
      #1;
      if ({stall_F, stall_D, flush_D, flush_E} !== 4'b1111) begin
         errors++; $display("FAIL branch_in_stall got=%b exp=1111", {stall_F, stall_D, flush_D, flush_E});
      end
      checks++;
      idle();
      pc_src_E = 1'b1;
      #1;
      if ({stall_F, stall_D, flush_D, flush_E} !== 4'b0011) begin
         errors++; $display("FAIL branch_only got=%b exp=0011", {stall_F, stall_D, flush_D, flush_E});
      end
      checks++;
      tick();
   endtask

   task automatic test_rst_mid_div();
      do_reset();
      idle();
      lo_start_E = 1'b1; rd_E = 5'd9;
      tick();
      idle();
      rs_D = {5'd9, 5'd0}; rd_M = 5'd4; reg_wr_M = 1'b1; rs_E = {5'd4, 5'd4};
      #1;
      if (stall_D !== 1'b1) begin errors++; $display("FAIL rst_mid_div_pre got=%b exp=1", stall_D); end
      checks++;
      rst = 1'b1;
      #1;
      if (obs !== 9'd0) begin errors++; $display("FAIL rst_mid_div_forced got=%b exp=%b", obs, 9'd0); end
      checks++;
      tick();
      rst = 1'b0;
      #1;
      if ({stall_D, flush_E, sb_err} !== 3'b000) begin
         errors++; $display("FAIL rst_mid_div_cleared got=%b exp=000", {stall_D, flush_E, sb_err});
      end
      checks++;
      tick();
   endtask

   task automatic test_random();
      logic [REG_AW-1:0] r;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         idle();
         for (int i = 0; i < NUM_SRC; i++) begin
            rs_D[i] = REG_AW'($urandom_range(0, 7));
            rs_E[i] = REG_AW'($urandom_range(0, 7));
         end
         rd_D     = REG_AW'($urandom_range(0, 7));
         rd_E     = REG_AW'($urandom_range(0, 7));
         rd_M     = REG_AW'($urandom_range(0, 7));
         rd_W     = REG_AW'($urandom_range(0, 7));
         reg_wr_M = 1'($urandom_range(0, 1));
         reg_wr_W = 1'($urandom_range(0, 1));
         load_E   = ($urandom_range(0, 3) == 0);
         pc_src_E = ($urandom_range(0, 7) == 0);
         lo_D     = ($urandom_range(0, 2) == 0);
         lo_start_E = (m_cnt < LO_MAX) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
         if (m_cnt > 0 && $urandom_range(0, 2) == 0) begin
            for (int t = 0; t < 8; t++) begin
               r = REG_AW'($urandom_range(0, 7));
               if (m_pend[r] || r == 0) begin
                  lo_done = 1'b1; lo_rd = r;
                  break;
               end
            end
         end else if ($urandom_range(0, 63) == 0) begin
            lo_done = 1'b1; lo_rd = REG_AW'($urandom_range(0, 7));
         end
         #1;
         if (obs !== exp_out()) begin
            errors++; $display("FAIL random cyc=%0d got=%b exp=%b", n, obs, exp_out());
         end
         checks++;
         tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      @(negedge clk);
      test_reset();
      test_forwarding();
      test_x0();
      test_load_use();
      test_div();
      test_capacity();
      test_branch_during_stall();
      test_rst_mid_div();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
